// File: rtl/lcd_reader_pkg.sv
// ----------------------------------------------------------------------------
// lcd_reader_pkg
// Shared definitions for the character-LCD read engine. Also intended for the
// LCD write controller so both sides agree on state encodings, register-select
// values, default bus timing and the busy-flag bit position.
// Contents:
//   state_e        read-engine FSM states
//   RS_CMD/RS_DATA register-select values (busy-flag/address vs. data)
//   DEF_*          default timing constants in clock cycles at 50 MHz
//   BF_BIT         bit index of the busy flag within the read byte
//   maxOf3         helper used to size the shared phase counter
// ----------------------------------------------------------------------------
package lcd_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EN_HI = 3'd2,
    ST_EN_LO = 3'd3,
    ST_ACK   = 3'd4
  } state_e;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int DEF_T_AS      = 3;
  localparam int DEF_T_EN_HI   = 25;
  localparam int DEF_T_EN_LO   = 25;
  localparam int DEF_MAX_POLLS = 1000;

  localparam int BF_BIT = 7;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// ----------------------------------------------------------------------------
// lcd_reader_if
// Host-side request/acknowledge bundle of the LCD read engine.
//   iREQ      host -> reader  start a read (only looked at while idle)
//   iRS       host -> reader  0 = busy-flag/address read, 1 = data read
//   iWAIT     host -> reader  with iRS=0, keep polling until BF clears
//   oACK      reader -> host  one-cycle completion pulse, oDATA valid
//   oDATA     reader -> host  last byte captured from the LCD
//   oTIMEOUT  reader -> host  wait mode gave up with BF still set
//   oBUSY     reader -> host  high whenever the reader is not idle
// master = host side, slave = reader side.
// ----------------------------------------------------------------------------
interface lcd_reader_if;

  logic       iREQ;
  logic       iRS;
  logic       iWAIT;
  logic       oACK;
  logic [7:0] oDATA;
  logic       oTIMEOUT;
  logic       oBUSY;

  modport master (
    output iREQ, iRS, iWAIT,
    input  oACK, oDATA, oTIMEOUT, oBUSY
  );

  modport slave (
    input  iREQ, iRS, iWAIT,
    output oACK, oDATA, oTIMEOUT, oBUSY
  );

endinterface

// File: rtl/lcd_reader_sync2.sv
// ----------------------------------------------------------------------------
// lcd_reader_sync2
// Two-flop synchronizer for the LCD data bus. The LCD drives its data pins
// asynchronously to our clock, so the bus is double-registered before the
// read engine captures it.
//   clk_i  system clock
//   rst_i  asynchronous reset, active-high; clears both stages
//   d_i    asynchronous input bus
//   q_o    synchronized bus, two clocks behind d_i
// ----------------------------------------------------------------------------
module lcd_reader_sync2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage gives it a full cycle to settle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lcd_reader.sv
// ----------------------------------------------------------------------------
// lcd_reader
// Read engine for an HD44780-class character LCD. Performs busy-flag/address
// reads (RS=0) and DDRAM/CGRAM data reads (RS=1) with RW=1, optionally polling
// the busy flag until it clears or a poll budget runs out. The surrounding top
// muxes RS/RW/EN between this block and the write controller using
// LCD_ACTIVE and keeps the data bus tri-stated while LCD_ACTIVE is high.
// Parameters:
//   T_AS       RS/RW setup cycles before EN rises
//   T_EN_HI    EN high cycles; the bus is sampled on the last one
//   T_EN_LO    EN low cycles after the pulse with RS/RW still held
//   MAX_POLLS  EN pulses allowed in wait mode before giving up (1..65535)
// Ports:
//   iCLK, iRST   clock and asynchronous active-high reset
//   host         request/acknowledge bundle (lcd_reader_if.slave)
//   LCD_ACTIVE   high while this block owns RS/RW/EN (same as oBUSY)
//   LCD_RS/RW/EN LCD control strobes
//   LCD_DATA_IN  LCD data bus, input side
// ----------------------------------------------------------------------------
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int T_AS      = DEF_T_AS,
  parameter int T_EN_HI   = DEF_T_EN_HI,
  parameter int T_EN_LO   = DEF_T_EN_LO,
  parameter int MAX_POLLS = DEF_MAX_POLLS
) (
  input  logic             iCLK,
  input  logic             iRST,
  lcd_reader_if.slave      host,
  output logic             LCD_ACTIVE,
  output logic             LCD_RS,
  output logic             LCD_RW,
  output logic             LCD_EN,
  input  logic [7:0]       LCD_DATA_IN
);

  // One counter serves all three bus phases, so it is sized for the longest.
  localparam int T_MAX = maxOf3(T_AS, T_EN_HI, T_EN_LO);
  localparam int CW    = $clog2(T_MAX + 1);
  localparam int PW    = $clog2(MAX_POLLS + 1);

  localparam logic [CW-1:0] AS_LAST    = CW'(T_AS - 1);
  localparam logic [CW-1:0] EN_HI_LAST = CW'(T_EN_HI - 1);
  localparam logic [CW-1:0] EN_LO_LAST = CW'(T_EN_LO - 1);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [PW-1:0] pollCnt_q,  pollCnt_d;
  logic          rsSel_q,    rsSel_d;
  logic          waitMode_q, waitMode_d;
  logic [7:0]    data_q,     data_d;
  logic          timeout_q,  timeout_d;
  logic          ack_q;
  logic          busy_q;
  logic          en_q;
  logic          rs_q;
  logic          rw_q;

  logic [7:0]    syncData;
  logic [PW-1:0] pollInc;

  lcd_reader_sync2 #(
    .WIDTH (8)
  ) uSync (
    .clk_i (iCLK),
    .rst_i (iRST),
    .d_i   (LCD_DATA_IN),
    .q_o   (syncData)
  );

  assign pollInc = pollCnt_q + PW'(1);

  // Next-state logic. The counter free-runs inside a phase and is cleared on
  // every phase change. The poll decision uses the freshly incremented count,
  // so wait mode never issues more than MAX_POLLS EN pulses.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    pollCnt_d  = pollCnt_q;
    rsSel_d    = rsSel_q;
    waitMode_d = waitMode_q;
    data_d     = data_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (host.iREQ) begin
          state_d    = ST_SETUP;
          rsSel_d    = host.iRS;
          // Busy-flag polling only makes sense for command-register reads.
          waitMode_d = host.iWAIT & (host.iRS == RS_CMD);
          pollCnt_d  = '0;
        end
      end

      ST_SETUP: begin
        if (cnt_q == AS_LAST) begin
          state_d = ST_EN_HI;
          cnt_d   = '0;
        end
      end

      ST_EN_HI: begin
        if (cnt_q == EN_HI_LAST) begin
          state_d = ST_EN_LO;
          cnt_d   = '0;
          data_d  = syncData;
        end
      end

      ST_EN_LO: begin
        if (cnt_q == EN_LO_LAST) begin
          cnt_d     = '0;
          pollCnt_d = pollInc;
          if (waitMode_q && data_q[BF_BIT] && (pollInc < POLL_LIMIT)) begin
            state_d = ST_SETUP;
          end else begin
            state_d   = ST_ACK;
            timeout_d = waitMode_q & data_q[BF_BIT];
          end
        end
      end

      ST_ACK: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers. Outputs are decoded from the next state so
  // the LCD strobes come straight off flops, glitch-free, and stay aligned
  // with the state they belong to.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pollCnt_q  <= '0;
      rsSel_q    <= RS_CMD;
      waitMode_q <= 1'b0;
      data_q     <= 8'h00;
      timeout_q  <= 1'b0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      rs_q       <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pollCnt_q  <= pollCnt_d;
      rsSel_q    <= rsSel_d;
      waitMode_q <= waitMode_d;
      data_q     <= data_d;
      timeout_q  <= timeout_d;
      ack_q      <= (state_d == ST_ACK);
      busy_q     <= (state_d != ST_IDLE);
      en_q       <= (state_d == ST_EN_HI);
      rw_q       <= (state_d inside {ST_SETUP, ST_EN_HI, ST_EN_LO});
      rs_q       <= (state_d inside {ST_SETUP, ST_EN_HI, ST_EN_LO}) & rsSel_d;
    end
  end

  assign host.oACK     = ack_q;
  assign host.oDATA    = data_q;
  assign host.oTIMEOUT = timeout_q;
  assign host.oBUSY    = busy_q;

  assign LCD_ACTIVE = busy_q;
  assign LCD_EN     = en_q;
  assign LCD_RS     = rs_q;
  assign LCD_RW     = rw_q;

endmodule

// File: tb/tb_lcd_reader.sv
// ----------------------------------------------------------------------------
// tb_lcd_reader
// Self-checking bench for lcd_reader. Each transaction's expected outcome
// (number of EN pulses, captured byte, timeout, latency) is derived from the
// sequence of bytes the simulated LCD presents, one byte per EN pulse.
// ----------------------------------------------------------------------------
module tb_lcd_reader;

  localparam int T_AS        = 3;
  localparam int T_EN_HI     = 25;
  localparam int T_EN_LO     = 25;
  localparam int MAX_POLLS   = 4;
  localparam int POLL_CYCLES = T_AS + T_EN_HI + T_EN_LO;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       LCD_ACTIVE;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] busIn = 8'h00;

  int checks   = 0;
  int failures = 0;

  // Byte presented by the LCD on each successive EN pulse; the last entry
  // repeats if the reader keeps polling past the end of the list.
  logic [7:0] busQ[$];

  lcd_reader_if hostIf();

  lcd_reader #(
    .T_AS      (T_AS),
    .T_EN_HI   (T_EN_HI),
    .T_EN_LO   (T_EN_LO),
    .MAX_POLLS (MAX_POLLS)
  ) dut (
    .iCLK        (iCLK),
    .iRST        (iRST),
    .host        (hostIf),
    .LCD_ACTIVE  (LCD_ACTIVE),
    .LCD_RS      (LCD_RS),
    .LCD_RW      (LCD_RW),
    .LCD_EN      (LCD_EN),
    .LCD_DATA_IN (busIn)
  );

  always #5 iCLK = ~iCLK;

  // Single point through which every comparison is counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference outcome of one read: one byte per poll, keep polling only for
  // a wait-mode command read that still sees BF=1 and has budget left.
  function automatic void refModel(input bit rs, input bit wt, output int polls,
                                   output logic [7:0] data, output bit tmo);
    bit keepGoing;
    polls     = 0;
    data      = 8'h00;
    keepGoing = 1'b1;
    while (keepGoing) begin
      data      = busQ[(polls < busQ.size()) ? polls : busQ.size() - 1];
      polls     = polls + 1;
      keepGoing = wt && !rs && data[7] && (polls < MAX_POLLS);
    end
    tmo = wt && !rs && data[7];
  endfunction

  // Runs one transaction against the bytes in busQ and checks the outcome.
  task automatic applyStimulus(input string tag, input bit rs, input bit wt);
    int         expPolls;
    logic [7:0] expData;
    bit         expTmo;
    int         cycles, pulses, idx, hiLen, badHi, badCtl, firstRise, limit;
    bit         enPrev, gotAck;

    refModel(rs, wt, expPolls, expData, expTmo);
    cycles = 0; pulses = 0; idx = 0; hiLen = 0; badHi = 0; badCtl = 0;
    firstRise = -1; enPrev = 1'b0; gotAck = 1'b0;
    limit = MAX_POLLS * POLL_CYCLES + 20;

    busIn = busQ[0];
    @(posedge iCLK); #1;
    hostIf.iREQ  = 1'b1;
    hostIf.iRS   = rs;
    hostIf.iWAIT = wt;
    @(posedge iCLK); #1;
    cycles = 1;
    hostIf.iREQ  = 1'b0;
    hostIf.iRS   = 1'($urandom);
    hostIf.iWAIT = 1'($urandom);
    checkOutput({tag, "_busy"}, hostIf.oBUSY, 1);

    while (!gotAck && cycles <= limit) begin
      if (hostIf.oACK) begin
        gotAck = 1'b1;
      end else begin
        if (hostIf.oBUSY !== 1'b1 || LCD_ACTIVE !== 1'b1 ||
            LCD_RW !== 1'b1 || LCD_RS !== rs) badCtl++;
        if (LCD_EN && !enPrev) begin
          pulses++;
          hiLen = 0;
          if (firstRise < 0) firstRise = cycles;
        end
        if (LCD_EN) hiLen++;
        if (!LCD_EN && enPrev) begin
          if (hiLen != T_EN_HI) badHi++;
          idx++;
          busIn = busQ[(idx < busQ.size()) ? idx : busQ.size() - 1];
        end
        enPrev = LCD_EN;
        @(posedge iCLK); #1;
        cycles++;
      end
    end

    checkOutput({tag, "_ack"}, gotAck, 1);
    checkOutput({tag, "_latency"}, cycles, expPolls * POLL_CYCLES + 1);
    checkOutput({tag, "_pulses"}, pulses, expPolls);
    checkOutput({tag, "_firstEn"}, firstRise, T_AS + 1);
    checkOutput({tag, "_enWidth"}, badHi, 0);
    checkOutput({tag, "_ctl"}, badCtl, 0);
    checkOutput({tag, "_data"}, hostIf.oDATA, expData);
    checkOutput({tag, "_timeout"}, hostIf.oTIMEOUT, expTmo);
    checkOutput({tag, "_ackBus"}, {LCD_EN, LCD_RW, LCD_RS}, 0);
    @(posedge iCLK); #1;
    checkOutput({tag, "_ackPulse"}, hostIf.oACK, 0);
    checkOutput({tag, "_idle"}, {hostIf.oBUSY, LCD_ACTIVE}, 0);
    checkOutput({tag, "_hold"}, {hostIf.oTIMEOUT, hostIf.oDATA}, {expTmo, expData});
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n, cycles, pulses, acks, nBusy;
    bit         rs, wt, enPrev;
    logic [7:0] b;

    hostIf.iREQ  = 1'b0;
    hostIf.iRS   = 1'b0;
    hostIf.iWAIT = 1'b0;

    // Reset state
    #1;
    checkOutput("reset_ctl", {LCD_EN, LCD_RW, LCD_RS, LCD_ACTIVE}, 0);
    checkOutput("reset_host", {hostIf.oACK, hostIf.oBUSY, hostIf.oTIMEOUT}, 0);
    checkOutput("reset_data", hostIf.oDATA, 8'h00);
    #21 iRST = 1'b0;
    repeat (3) @(posedge iCLK);

    // Single busy-flag/address read
    busQ = '{8'h25};
    applyStimulus("cmdRead", 1'b0, 1'b0);

    // Reset asserted while idle clears the captured byte
    #2 iRST = 1'b1; #1;
    checkOutput("idleRst_data", hostIf.oDATA, 8'h00);
    checkOutput("idleRst_ctl", {LCD_ACTIVE, LCD_EN, LCD_RW, LCD_RS, hostIf.oBUSY}, 0);
    @(posedge iCLK); #3 iRST = 1'b0;
    repeat (2) @(posedge iCLK);

    // Data read, and data read with iWAIT set (wait must be ignored)
    busQ = '{8'h48};
    applyStimulus("dataRead", 1'b1, 1'b0);
    busQ = '{8'hC8, 8'h01};
    applyStimulus("dataWaitIgnored", 1'b1, 1'b1);

    // Non-wait command read with BF set: no timeout
    busQ = '{8'hA3};
    applyStimulus("cmdBusyNoWait", 1'b0, 1'b0);

    // Wait mode, BF clears on the 4th poll
    busQ = '{8'h80, 8'h80, 8'h80, 8'h05};
    applyStimulus("waitClears", 1'b0, 1'b1);

    // Wait mode, BF stuck: gives up after MAX_POLLS pulses
    busQ = '{8'hFF};
    applyStimulus("waitTimeout", 1'b0, 1'b1);

    // Randomized transactions
    for (int i = 0; i < 10; i++) begin
      rs    = 1'($urandom);
      wt    = 1'($urandom);
      nBusy = $urandom_range(0, 5);
      busQ.delete();
      if (wt && !rs) begin
        for (int k = 0; k < nBusy; k++) begin
          b = 8'($urandom);
          busQ.push_back(b | 8'h80);
        end
        b = 8'($urandom);
        busQ.push_back(b & 8'h7F);
      end else begin
        b = 8'($urandom);
        busQ.push_back(b);
      end
      applyStimulus($sformatf("rand%0d", i), rs, wt);
    end

    // Reset in the 10th cycle of EN high, with iREQ held throughout
    busIn = 8'h5A;
    @(posedge iCLK); #1;
    hostIf.iREQ  = 1'b1;
    hostIf.iRS   = 1'b0;
    hostIf.iWAIT = 1'b0;
    n = 0;
    while (!LCD_EN && n < 100) begin
      @(posedge iCLK); #1;
      n++;
    end
    checkOutput("midRst_reachEn", LCD_EN, 1);
    repeat (9) begin
      @(posedge iCLK); #1;
    end
    checkOutput("midRst_enBefore", LCD_EN, 1);
    #2 iRST = 1'b1; #1;
    checkOutput("midRst_enDrop", {LCD_EN, LCD_RW, LCD_RS}, 0);
    checkOutput("midRst_outs", {hostIf.oACK, hostIf.oBUSY, LCD_ACTIVE, hostIf.oTIMEOUT}, 0);
    checkOutput("midRst_data", hostIf.oDATA, 8'h00);
    @(posedge iCLK); #3 iRST = 1'b0;

    cycles = 0; pulses = 0; acks = 0; enPrev = 1'b0;
    while (acks == 0 && cycles < 200) begin
      @(posedge iCLK); #1;
      cycles++;
      if (LCD_EN && !enPrev) pulses++;
      enPrev = LCD_EN;
      if (hostIf.oACK) acks++;
    end
    checkOutput("heldReq_latency", cycles, POLL_CYCLES + 1);
    checkOutput("heldReq_pulses", pulses, 1);
    checkOutput("heldReq_data", hostIf.oDATA, 8'h5A);
    @(posedge iCLK); #1;
    checkOutput("heldReq_idleGap", {hostIf.oACK, hostIf.oBUSY}, 0);
    @(posedge iCLK); #1;
    checkOutput("heldReq_restart", hostIf.oBUSY, 1);
    hostIf.iREQ = 1'b0;
    n = 0;
    while (!hostIf.oACK && n < 200) begin
      @(posedge iCLK); #1;
      n++;
    end
    checkOutput("heldReq_secondAck", hostIf.oACK, 1);
    @(posedge iCLK); #1;
    checkOutput("heldReq_settle", hostIf.oBUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
